// File: rtl/regbank_pkg.sv
// regbank_pkg: shared defaults and address-width helper for the register bank.
package regbank_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/regbank_rdport.sv
// regbank_rdport: one registered read port with write-first bypass, clear-first and r0 masking.
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ZERO_R0 = 1,
  parameter int AW      = clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
  input  logic                        we_i,
  input  logic [AW-1:0]               waddr_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        clr_i,
  input  logic                        re_i,
  input  logic [AW-1:0]               raddr_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        rvalid_o
);
  logic [WIDTH-1:0] hit, rdata_d, rdata_q;
  logic             rvalid_q;
  // clear and r0 masking dominate the bypassed value, so the read sees the state after this edge
  always_comb begin
    hit     = (we_i && waddr_i == raddr_i) ? wdata_i : regs_i[raddr_i];
    rdata_d = !re_i ? rdata_q : (clr_i || (ZERO_R0 != 0 && raddr_i == '0)) ? '0 : hit;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= re_i;
    end
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
endmodule

// File: rtl/regbank.sv
// regbank: DEPTH x WIDTH register file, one write port, two registered read ports, sync clear.
module regbank
  import regbank_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ZERO_R0 = 1,
  localparam int AW     = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr,
  input  logic             rea,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             reb,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_a,
  output logic             rvalid_b
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]            wen;
  always_comb begin
    wen        = '0;
    wen[waddr] = we;
    wen[0]     = wen[0] & (ZERO_R0 == 0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '0;
    else for (int i = 0; i < DEPTH; i++) mem_q[i] <= clr ? '0 : wen[i] ? wdata : mem_q[i];
  regbank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_R0(ZERO_R0), .AW(AW)) u_rd_a (
    .clk(clk), .rst(rst), .regs_i(mem_q), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .clr_i(clr), .re_i(rea), .raddr_i(raddr_a), .rdata_o(rdata_a), .rvalid_o(rvalid_a)
  );
  regbank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_R0(ZERO_R0), .AW(AW)) u_rd_b (
    .clk(clk), .rst(rst), .regs_i(mem_q), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .clr_i(clr), .re_i(reb), .raddr_i(raddr_b), .rdata_o(rdata_b), .rvalid_o(rvalid_b)
  );
endmodule
